// File: rtl/uncache_ctrl_pkg.sv
// uncache_ctrl_pkg: state encoding shared by the uncached access controller
package uncache_ctrl_pkg;
  typedef enum logic [2:0] {UC_IDLE, UC_RREQ, UC_RWAIT, UC_WREQ, UC_WWAIT, UC_DONE} uc_state_t;
endpackage

// File: rtl/uncache_ctrl.sv
// uncache_ctrl: turns a stalled core data access into one single-beat bridge read or write
module uncache_ctrl
  import uncache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_en,
  input  logic [3:0]        req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stallreq,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_size,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_size,
  output logic [3:0]        wr_wstrb,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_rdy,
  input  logic              wr_done
);
  uc_state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] wen_q;
  logic [DATA_W-1:0] wdata_q;
  function automatic logic [1:0] size_of(input logic [3:0] wen);
    return (wen == 4'b0001 || wen == 4'b0010 || wen == 4'b0100 || wen == 4'b1000) ? 2'd0 :
           (wen == 4'b0011 || wen == 4'b1100) ? 2'd1 : 2'd2;
  endfunction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= UC_IDLE;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= next;
      if (state == UC_IDLE && req_en) begin
        addr_q  <= req_addr;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
      end
      if (state == UC_RWAIT && ret_valid) rdata <= ret_data;
    end
  end
  always_comb begin
    next = state;
    case (state)
      UC_IDLE:  next = req_en ? (req_wen != 4'd0 ? UC_WREQ : UC_RREQ) : UC_IDLE;
      UC_RREQ:  next = rd_rdy ? UC_RWAIT : UC_RREQ;
      UC_RWAIT: next = ret_valid ? UC_DONE : UC_RWAIT;
      UC_WREQ:  next = wr_rdy ? UC_WWAIT : UC_WREQ;
      UC_WWAIT: next = wr_done ? UC_DONE : UC_WWAIT;
      default:  next = UC_IDLE;
    endcase
  end
  // reset gates the stall so a request held by the core during reset reads as idle
  assign stallreq = resetn && ((state == UC_IDLE && req_en) || state inside {UC_RREQ, UC_RWAIT, UC_WREQ, UC_WWAIT});
  assign rd_req   = state == UC_RREQ;
  assign rd_addr  = addr_q;
  assign rd_size  = 2'd2;
  assign wr_req   = state == UC_WREQ;
  assign wr_addr  = addr_q;
  assign wr_wstrb = wen_q;
  assign wr_data  = wdata_q;
  assign wr_size  = wr_req ? size_of(wen_q) : 2'd0;
endmodule
